// File: rtl/mmio_pwm_led_responder.sv
// mmio_pwm_led_responder: word-addressed register window on the core's data port.
// Drives four board LEDs and NCH PWM channels. Loads return registered read data.
// PERIOD and DUTY are software shadows. The counter runs on "active" copies that are
// reloaded at the wrap point, or when EN rises, so a period never changes shape halfway.
module mmio_pwm_led_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0200,
  parameter int          NCH       = 4,
  parameter int          CW        = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           MemWrite,
  input  logic           MemRead,
  input  logic [31:0]    DataAdr,
  input  logic [31:0]    WriteData,
  output logic [31:0]    ReadData,
  output logic           hit,
  output logic [3:0]     leds,
  output logic [NCH-1:0] pwm_out
);

  logic           in_win_s;
  logic           wr_s;
  logic           rd_s;
  logic           duty_ok_s;
  logic           wrap_s;
  logic           load_s;
  logic [2:0]     off_s;
  logic           en_r;
  logic           en_nxt_s;
  logic           err_r;
  logic           err_nxt_s;
  logic [3:0]     leds_nxt_s;
  logic [CW-1:0]  period_sh_r;
  logic [CW-1:0]  period_sh_nxt_s;
  logic [CW-1:0]  period_act_r;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  cnt_nxt_s;
  logic [CW-1:0]  duty_sh_r     [NCH];
  logic [CW-1:0]  duty_sh_nxt_s [NCH];
  logic [CW-1:0]  duty_act_r    [NCH];
  logic [NCH-1:0] pwm_nxt_s;
  logic [31:0]    rd_val_s;
  logic           unused_s;

  assign in_win_s  = (DataAdr[31:5] == BASE_ADDR[31:5]);
  assign off_s     = DataAdr[4:2];
  assign wr_s      = MemWrite & in_win_s;
  assign rd_s      = MemRead & in_win_s;
  // Offsets 4..7 are DUTY[0..3]; only the first NCH of them are backed by storage.
  assign duty_ok_s = ({29'd0, off_s} < (32'd4 + 32'(NCH)));
  // Byte-lane bits and upper store bits are intentionally ignored.
  assign unused_s  = ^{DataAdr[1:0], WriteData[31:CW]};

  // Next values of the software-visible registers after an in-window store.
  always_comb begin
    en_nxt_s        = en_r;
    period_sh_nxt_s = period_sh_r;
    leds_nxt_s      = leds;
    err_nxt_s       = err_r;
    duty_sh_nxt_s   = duty_sh_r;
    if (wr_s) begin
      case (off_s)
        3'd0: en_nxt_s = WriteData[0];
        3'd1: period_sh_nxt_s = WriteData[CW-1:0];
        3'd2: leds_nxt_s = WriteData[3:0];
        3'd3: err_nxt_s = err_r & ~WriteData[0];
        default: begin
          if (duty_ok_s) begin
            for (int i = 0; i < NCH; i++) begin
              if (32'(off_s[1:0]) == 32'(i)) begin
                duty_sh_nxt_s[i] = WriteData[CW-1:0];
              end else begin
                duty_sh_nxt_s[i] = duty_sh_r[i];
              end
            end
          end else begin
            err_nxt_s = 1'b1;
          end
        end
      endcase
    end else begin
      en_nxt_s = en_r;
    end
  end

  // Read mux: shadows are what software sees for PERIOD and DUTY.
  always_comb begin
    rd_val_s = 32'd0;
    case (off_s)
      3'd0: rd_val_s = {31'd0, en_r};
      3'd1: rd_val_s = 32'(period_sh_r);
      3'd2: rd_val_s = {28'd0, leds};
      3'd3: rd_val_s = {31'd0, err_r};
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (32'(off_s[1:0]) == 32'(i)) begin
            rd_val_s = 32'(duty_sh_r[i]);
          end else begin
            rd_val_s = rd_val_s;
          end
        end
      end
    endcase
  end

  // A store landing on the wrap cycle is picked up because the reload uses the next shadow values.
  assign wrap_s = en_r & (cnt_r == period_act_r);
  assign load_s = wrap_s | (~en_r & en_nxt_s);

  // Counter advance and PWM compare against the active duty values.
  always_comb begin
    cnt_nxt_s = {CW{1'b0}};
    pwm_nxt_s = {NCH{1'b0}};
    if (en_r && !wrap_s) begin
      cnt_nxt_s = cnt_r + CW'(1);
    end else begin
      cnt_nxt_s = {CW{1'b0}};
    end
    for (int i = 0; i < NCH; i++) begin
      pwm_nxt_s[i] = en_r & (cnt_r < duty_act_r[i]);
    end
  end

  // Software-visible registers and their shadows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_r        <= 1'b0;
      err_r       <= 1'b0;
      leds        <= 4'd0;
      period_sh_r <= {CW{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        duty_sh_r[i] <= {CW{1'b0}};
      end
    end else begin
      en_r        <= en_nxt_s;
      err_r       <= err_nxt_s;
      leds        <= leds_nxt_s;
      period_sh_r <= period_sh_nxt_s;
      duty_sh_r   <= duty_sh_nxt_s;
    end
  end

  // PWM engine: active copies, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_act_r <= {CW{1'b0}};
      cnt_r        <= {CW{1'b0}};
      pwm_out      <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        duty_act_r[i] <= {CW{1'b0}};
      end
    end else begin
      cnt_r   <= cnt_nxt_s;
      pwm_out <= pwm_nxt_s;
      if (load_s) begin
        period_act_r <= period_sh_nxt_s;
        duty_act_r   <= duty_sh_nxt_s;
      end else begin
        period_act_r <= period_act_r;
      end
    end
  end

  // Bus response: load data holds between loads; hit flags the last in-window access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ReadData <= 32'd0;
      hit      <= 1'b0;
    end else begin
      if (MemRead) begin
        ReadData <= rd_s ? rd_val_s : 32'd0;
      end else begin
        ReadData <= ReadData;
      end
      hit <= (MemWrite | MemRead) & in_win_s;
    end
  end

endmodule

// File: tb/tb_mmio_pwm_led_responder.sv
// Bench for mmio_pwm_led_responder (built with NCH=3 so DUTY[3] is an invalid target).
// The reference model keeps register contents as plain integers.
// It advances one step per clock edge, following the register map and PWM rules.
module tb_mmio_pwm_led_responder;
  localparam logic [31:0] BASE = 32'h0000_0200;
  localparam int          NCH  = 3;
  localparam int          CW   = 16;

  logic           clk;
  logic           reset;
  logic           MemWrite;
  logic           MemRead;
  logic [31:0]    DataAdr;
  logic [31:0]    WriteData;
  logic [31:0]    ReadData;
  logic           hit;
  logic [3:0]     leds;
  logic [NCH-1:0] pwm_out;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic           m_en;
  logic           m_err;
  logic           m_hit;
  logic [3:0]     m_leds;
  logic [NCH-1:0] m_pwm;
  logic [31:0]    m_rdata;
  int             m_period_sh;
  int             m_period_act;
  int             m_cnt;
  int             m_duty_sh  [NCH];
  int             m_duty_act [NCH];

  mmio_pwm_led_responder #(.BASE_ADDR(BASE), .NCH(NCH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .DataAdr(DataAdr), .WriteData(WriteData), .ReadData(ReadData),
    .hit(hit), .leds(leds), .pwm_out(pwm_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic m_reset();
    m_en = 1'b0; m_err = 1'b0; m_hit = 1'b0; m_leds = 4'd0; m_pwm = '0; m_rdata = 32'd0;
    m_period_sh = 0; m_period_act = 0; m_cnt = 0;
    for (int k = 0; k < NCH; k++) begin
      m_duty_sh[k] = 0;
      m_duty_act[k] = 0;
    end
  endtask

  function automatic logic [31:0] m_read(input int off);
    logic [31:0] v;
    v = 32'd0;
    case (off)
      0: v = {31'd0, m_en};
      1: v = 32'(m_period_sh);
      2: v = {28'd0, m_leds};
      3: v = {31'd0, m_err};
      default: if (off - 4 < NCH) v = 32'(m_duty_sh[off - 4]);
    endcase
    return v;
  endfunction

  // One clock edge of the reference model, given the bus inputs sampled at that edge.
  task automatic model_edge(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] base_v;
    logic in_win, old_en, wrap;
    int off, ncnt;
    logic [NCH-1:0] npwm;
    base_v = BASE;
    in_win = (a[31:5] == base_v[31:5]);
    off = int'(a[4:2]);
    if (r) m_rdata = in_win ? m_read(off) : 32'd0;
    m_hit = (w || r) && in_win;
    for (int k = 0; k < NCH; k++) npwm[k] = m_en && (m_cnt < m_duty_act[k]);
    wrap = m_en && (m_cnt == m_period_act);
    ncnt = (!m_en || wrap) ? 0 : m_cnt + 1;
    old_en = m_en;
    if (w && in_win) begin
      case (off)
        0: m_en = d[0];
        1: m_period_sh = int'(d[15:0]);
        2: m_leds = d[3:0];
        3: if (d[0]) m_err = 1'b0;
        default: if (off - 4 < NCH) m_duty_sh[off - 4] = int'(d[15:0]); else m_err = 1'b1;
      endcase
    end
    if (wrap || (!old_en && m_en)) begin
      m_period_act = m_period_sh;
      for (int k = 0; k < NCH; k++) m_duty_act[k] = m_duty_sh[k];
    end
    m_cnt = ncnt;
    m_pwm = npwm;
  endtask

  task automatic tick(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    MemWrite = w; MemRead = r; DataAdr = a; WriteData = d;
    @(posedge clk);
    model_edge(w, r, a, d);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; DataAdr = 32'd0; WriteData = 32'd0;
    m_reset();
    #12;
    checks++; if (leds !== 4'd0) begin errors++; $display("FAIL reset_leds: got %h expected 0", leds); end
    checks++; if (pwm_out !== 3'd0) begin errors++; $display("FAIL reset_pwm: got %b expected 0", pwm_out); end
    checks++; if (ReadData !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", ReadData); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", hit); end
    reset = 1'b1;
  endtask

  task automatic test_leds();
    tick(1'b1, 1'b0, BASE + 32'h8, 32'hA);
    checks++; if (leds !== 4'hA) begin errors++; $display("FAIL leds_store: got %h expected a", leds); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL leds_hit: got %b expected 1", hit); end
    tick(1'b0, 1'b1, BASE + 32'h8, 32'd0);
    checks++; if (ReadData !== 32'hA) begin errors++; $display("FAIL leds_load: got %h expected a", ReadData); end
  endtask

  task automatic test_pwm_basic();
    int highs;
    tick(1'b1, 1'b0, BASE + 32'h4, 32'd9);
    tick(1'b1, 1'b0, BASE + 32'h10, 32'd3);
    tick(1'b1, 1'b0, BASE + 32'h0, 32'd1);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      highs += int'(pwm_out[0]);
      checks++; if (pwm_out !== m_pwm) begin errors++; $display("FAIL pwm_duty3: got %b expected %b", pwm_out, m_pwm); end
    end
    checks++; if (highs != 6) begin errors++; $display("FAIL pwm_duty3_count: got %0d expected 6", highs); end
    tick(1'b1, 1'b0, BASE + 32'h10, 32'd0);
    for (int i = 0; i < 11; i++) idle();
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      highs += int'(pwm_out[0]);
    end
    checks++; if (highs != 0) begin errors++; $display("FAIL pwm_duty0_count: got %0d expected 0", highs); end
    tick(1'b1, 1'b0, BASE + 32'h10, 32'd10);
    for (int i = 0; i < 11; i++) idle();
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      highs += int'(pwm_out[0]);
      checks++; if (pwm_out !== m_pwm) begin errors++; $display("FAIL pwm_duty10: got %b expected %b", pwm_out, m_pwm); end
    end
    checks++; if (highs != 20) begin errors++; $display("FAIL pwm_duty10_count: got %0d expected 20", highs); end
  endtask

  task automatic test_mid_period();
    int highs_a, highs_b, guard;
    tick(1'b1, 1'b0, BASE + 32'h10, 32'd3);
    for (int i = 0; i < 12; i++) idle();
    guard = 0;
    while (m_cnt != 1 && guard < 30) begin
      idle();
      guard++;
    end
    checks++; if (m_cnt != 1) begin errors++; $display("FAIL mid_sync: got %0d expected 1", m_cnt); end
    tick(1'b1, 1'b0, BASE + 32'h10, 32'd7);
    highs_a = 0; highs_b = 0;
    for (int i = 1; i <= 18; i++) begin
      idle();
      if (i <= 8) highs_a += int'(pwm_out[0]); else highs_b += int'(pwm_out[0]);
      checks++; if (pwm_out !== m_pwm) begin errors++; $display("FAIL mid_pwm: got %b expected %b", pwm_out, m_pwm); end
    end
    checks++; if (highs_a != 1) begin errors++; $display("FAIL mid_old_tail: got %0d expected 1", highs_a); end
    checks++; if (highs_b != 7) begin errors++; $display("FAIL mid_new_period: got %0d expected 7", highs_b); end
  endtask

  task automatic test_err();
    tick(1'b1, 1'b0, BASE + 32'h1C, 32'h1234);
    tick(1'b0, 1'b1, BASE + 32'hC, 32'd0);
    checks++; if (ReadData !== 32'd1) begin errors++; $display("FAIL err_set: got %h expected 1", ReadData); end
    tick(1'b0, 1'b1, BASE + 32'h1C, 32'd0);
    checks++; if (ReadData !== 32'd0) begin errors++; $display("FAIL err_duty3_read: got %h expected 0", ReadData); end
    tick(1'b1, 1'b0, BASE + 32'hC, 32'd1);
    tick(1'b0, 1'b1, BASE + 32'hC, 32'd0);
    checks++; if (ReadData !== 32'd0) begin errors++; $display("FAIL err_clear: got %h expected 0", ReadData); end
  endtask

  task automatic test_outside();
    tick(1'b1, 1'b0, 32'd252, 32'h5);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL out_hit: got %b expected 0", hit); end
    checks++; if (leds !== 4'hA) begin errors++; $display("FAIL out_leds: got %h expected a", leds); end
    tick(1'b0, 1'b1, 32'd252, 32'd0);
    checks++; if (ReadData !== 32'd0) begin errors++; $display("FAIL out_load: got %h expected 0", ReadData); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL out_load_hit: got %b expected 0", hit); end
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 1'b1, BASE + 32'h8, 32'h3);
    checks++; if (ReadData !== 32'hA) begin errors++; $display("FAIL rw_old: got %h expected a", ReadData); end
    checks++; if (leds !== 4'h3) begin errors++; $display("FAIL rw_leds: got %h expected 3", leds); end
    tick(1'b0, 1'b1, BASE + 32'h8, 32'd0);
    checks++; if (ReadData !== 32'h3) begin errors++; $display("FAIL rw_new: got %h expected 3", ReadData); end
  endtask

  task automatic test_reset_midrun();
    int highs;
    tick(1'b1, 1'b0, BASE + 32'h4, 32'd5);
    tick(1'b1, 1'b0, BASE + 32'h10, 32'd2);
    tick(1'b1, 1'b0, BASE + 32'h0, 32'd1);
    for (int i = 0; i < 7; i++) idle();
    #3 reset = 1'b0;
    #1;
    checks++; if (leds !== 4'd0) begin errors++; $display("FAIL rst_mid_leds: got %h expected 0", leds); end
    checks++; if (pwm_out !== 3'd0) begin errors++; $display("FAIL rst_mid_pwm: got %b expected 0", pwm_out); end
    checks++; if (ReadData !== 32'd0) begin errors++; $display("FAIL rst_mid_rdata: got %h expected 0", ReadData); end
    m_reset();
    #12 reset = 1'b1;
    tick(1'b0, 1'b1, BASE + 32'h4, 32'd0);
    checks++; if (ReadData !== 32'd0) begin errors++; $display("FAIL rst_period: got %h expected 0", ReadData); end
    tick(1'b1, 1'b0, BASE + 32'h4, 32'd4);
    tick(1'b1, 1'b0, BASE + 32'h10, 32'd2);
    tick(1'b1, 1'b0, BASE + 32'h0, 32'd1);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      idle();
      highs += int'(pwm_out[0]);
      checks++; if (pwm_out !== m_pwm) begin errors++; $display("FAIL rst_restart: got %b expected %b", pwm_out, m_pwm); end
    end
    checks++; if (highs != 4) begin errors++; $display("FAIL rst_restart_count: got %0d expected 4", highs); end
  endtask

  task automatic test_random();
    logic w, r;
    logic [31:0] a, d;
    for (int i = 0; i < 600; i++) begin
      w = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) < 8) a = BASE + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      else if ($urandom_range(0, 1) == 0) a = 32'd252;
      else a = $urandom;
      if ($urandom_range(0, 9) == 0) d = $urandom;
      else d = 32'($urandom_range(0, 12));
      tick(w, r, a, d);
      checks++; if (ReadData !== m_rdata) begin errors++; $display("FAIL rnd_rdata: got %h expected %h", ReadData, m_rdata); end
      checks++; if (hit !== m_hit) begin errors++; $display("FAIL rnd_hit: got %b expected %b", hit, m_hit); end
      checks++; if (leds !== m_leds) begin errors++; $display("FAIL rnd_leds: got %h expected %h", leds, m_leds); end
      checks++; if (pwm_out !== m_pwm) begin errors++; $display("FAIL rnd_pwm: got %b expected %b", pwm_out, m_pwm); end
    end
  endtask

  initial begin
    test_reset();
    test_leds();
    test_pwm_basic();
    test_mid_period();
    test_err();
    test_outside();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
